// File: rtl/mc68681_tx_channel_if.sv
// Host bus bundle for one MC68681 transmit channel: chip select, direction,
// register address, write data and combinational read data.
interface mc68681_tx_channel_if;
  logic       CS;
  logic       R_W;
  logic       A1;
  logic       A0;
  logic [7:0] DATA;
  logic [7:0] DATA_OUT;

  modport master (output CS, R_W, A1, A0, DATA, input DATA_OUT);
  modport slave  (input CS, R_W, A1, A0, DATA, output DATA_OUT);
endinterface

// File: rtl/mc68681_tx_channel.sv
// MC68681 DUART transmit channel: register decode, THR and 16x-tick frame serialiser.
// Break control (command bits 3/4) is built only when MC68681_TX_BREAK_EN is defined.
module mc68681_tx_channel (
  input  logic                CLK,
  input  logic                _RESET,
  mc68681_tx_channel_if.slave bus,
  input  logic                BAUD_TICK,
  output logic                TXD,
  output logic                TxRDY,
  output logic                TxEMT
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5,
    S_BRKEND = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic       csPrev_q;
  logic [4:0] mr_q, mr_d;
  logic       enabled_q, enabled_d;
  logic       thrFull_q, thrFull_d;
  logic [7:0] thr_q, thr_d;
  logic [7:0] shift_q, shift_d;
  logic [4:0] tickCnt_q, tickCnt_d;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic [1:0] len_q, len_d;
  logic       parEn_q, parEn_d;
  logic       parOdd_q, parOdd_d;
  logic       stop2_q, stop2_d;
  logic       parAcc_q, parAcc_d;
`ifdef MC68681_TX_BREAK_EN
  logic       breakReq_q, breakReq_d;
`endif

  logic access, wrMode, wrCmd, wrThr, cmdReset, canLoad, tickEnd, stopEnd, load;

  // A held CS only acts on its first clock.
  assign access   = bus.CS && !csPrev_q;
  assign wrMode   = access && !bus.R_W && !bus.A1 && !bus.A0;
  assign wrCmd    = access && !bus.R_W &&  bus.A1 && !bus.A0;
  assign wrThr    = access && !bus.R_W &&  bus.A1 &&  bus.A0;
  assign cmdReset = wrCmd && bus.DATA[2];
  assign canLoad  = thrFull_q && enabled_q;
  assign tickEnd  = (tickCnt_q == 5'd15);
  assign stopEnd  = stop2_q ? (tickCnt_q == 5'd31) : tickEnd;

  assign TxRDY = enabled_q && !thrFull_q;
  assign TxEMT = enabled_q && !thrFull_q && (state_q == S_IDLE);

  always_comb begin
    bus.DATA_OUT = 8'h00;
    if (bus.CS && bus.R_W) begin
      if (!bus.A1 && !bus.A0)     bus.DATA_OUT = {3'b000, mr_q};
      else if (bus.A1 && !bus.A0) bus.DATA_OUT = {4'b0000, TxEMT, TxRDY, 2'b00};
    end
  end

  always_comb begin
    case (state_q)
      S_START, S_BREAK: TXD = 1'b0;
      S_DATA:           TXD = shift_q[0];
      S_PARITY:         TXD = parAcc_q ^ parOdd_q;
      default:          TXD = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mr_d      = mr_q;
    enabled_d = enabled_q;
    thrFull_d = thrFull_q;
    thr_d     = thr_q;
    shift_d   = shift_q;
    tickCnt_d = tickCnt_q;
    bitCnt_d  = bitCnt_q;
    len_d     = len_q;
    parEn_d   = parEn_q;
    parOdd_d  = parOdd_q;
    stop2_d   = stop2_q;
    parAcc_d  = parAcc_q;
`ifdef MC68681_TX_BREAK_EN
    breakReq_d = breakReq_q;
`endif
    load      = 1'b0;

    if (wrMode) mr_d = bus.DATA[4:0];
    if (wrCmd) begin
      if (bus.DATA[1])      enabled_d = 1'b0;
      else if (bus.DATA[0]) enabled_d = 1'b1;
    end

    if (BAUD_TICK) begin
      case (state_q)
        S_IDLE: begin
          if (canLoad) load = 1'b1;
`ifdef MC68681_TX_BREAK_EN
          if (breakReq_q) begin
            load    = 1'b0;
            state_d = S_BREAK;
          end
`endif
        end
        S_START: begin
          tickCnt_d = tickCnt_q + 5'd1;
          if (tickEnd) begin
            tickCnt_d = 5'd0;
            state_d   = S_DATA;
          end
        end
        S_DATA: begin
          tickCnt_d = tickCnt_q + 5'd1;
          if (tickEnd) begin
            tickCnt_d = 5'd0;
            parAcc_d  = parAcc_q ^ shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bitCnt_d  = bitCnt_q + 3'd1;
            if (bitCnt_q == ({1'b0, len_q} + 3'd4))
              state_d = parEn_q ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          tickCnt_d = tickCnt_q + 5'd1;
          if (tickEnd) begin
            tickCnt_d = 5'd0;
            state_d   = S_STOP;
          end
        end
        S_STOP: begin
          tickCnt_d = tickCnt_q + 5'd1;
          if (stopEnd) begin
            tickCnt_d = 5'd0;
            state_d   = S_IDLE;
            if (canLoad) load = 1'b1;
`ifdef MC68681_TX_BREAK_EN
            if (breakReq_q) begin
              load    = 1'b0;
              state_d = S_BREAK;
            end
`endif
          end
        end
`ifdef MC68681_TX_BREAK_EN
        S_BRKEND: begin
          tickCnt_d = tickCnt_q + 5'd1;
          if (tickEnd) begin
            tickCnt_d = 5'd0;
            state_d   = S_IDLE;
          end
        end
`endif
        default: ;
      endcase
    end

`ifdef MC68681_TX_BREAK_EN
    // Stop break leaves BREAK at once so the 16-tick mark starts counting immediately.
    if (wrCmd && bus.DATA[4]) begin
      breakReq_d = 1'b0;
      if (state_q == S_BREAK) begin
        state_d   = S_BRKEND;
        tickCnt_d = 5'd0;
      end
    end else if (wrCmd && bus.DATA[3]) begin
      breakReq_d = 1'b1;
    end
`endif

    // Frame format is frozen at load so MR writes only affect the next character.
    if (load) begin
      state_d   = S_START;
      tickCnt_d = 5'd0;
      bitCnt_d  = 3'd0;
      shift_d   = thr_q;
      len_d     = mr_q[1:0];
      parEn_d   = mr_q[2];
      parOdd_d  = mr_q[3];
      stop2_d   = mr_q[4];
      parAcc_d  = 1'b0;
      thrFull_d = 1'b0;
    end

    if (wrThr && enabled_q) begin
      thr_d     = bus.DATA;
      thrFull_d = 1'b1;
    end

    if (cmdReset) begin
      state_d   = S_IDLE;
      tickCnt_d = 5'd0;
      thrFull_d = 1'b0;
      enabled_d = 1'b0;
`ifdef MC68681_TX_BREAK_EN
      breakReq_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state_q   <= S_IDLE;
      csPrev_q  <= 1'b0;
      mr_q      <= 5'b00011;
      enabled_q <= 1'b0;
      thrFull_q <= 1'b0;
      thr_q     <= 8'h00;
      shift_q   <= 8'h00;
      tickCnt_q <= 5'd0;
      bitCnt_q  <= 3'd0;
      len_q     <= 2'd3;
      parEn_q   <= 1'b0;
      parOdd_q  <= 1'b0;
      stop2_q   <= 1'b0;
      parAcc_q  <= 1'b0;
`ifdef MC68681_TX_BREAK_EN
      breakReq_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      csPrev_q  <= bus.CS;
      mr_q      <= mr_d;
      enabled_q <= enabled_d;
      thrFull_q <= thrFull_d;
      thr_q     <= thr_d;
      shift_q   <= shift_d;
      tickCnt_q <= tickCnt_d;
      bitCnt_q  <= bitCnt_d;
      len_q     <= len_d;
      parEn_q   <= parEn_d;
      parOdd_q  <= parOdd_d;
      stop2_q   <= stop2_d;
      parAcc_q  <= parAcc_d;
`ifdef MC68681_TX_BREAK_EN
      breakReq_q <= breakReq_d;
`endif
    end
  end

endmodule

// File: tb/tb_mc68681_tx_channel.sv
// Bench for mc68681_tx_channel: table of frame formats, then queueing, disable,
// reset-transmitter, break (MC68681_TX_BREAK_EN aware) and async reset sequences.
module tb_mc68681_tx_channel;

  logic CLK = 1'b0;
  logic _RESET;
  logic BAUD_TICK = 1'b0;
  logic TXD, TxRDY, TxEMT;

  mc68681_tx_channel_if bus ();

  mc68681_tx_channel dut (
    .CLK       (CLK),
    ._RESET    (_RESET),
    .bus       (bus),
    .BAUD_TICK (BAUD_TICK),
    .TXD       (TXD),
    .TxRDY     (TxRDY),
    .TxEMT     (TxEMT)
  );

  always #5 CLK = ~CLK;

  // One baud tick every fourth clock, changed on the falling edge.
  int tickDiv = 0;
  always @(negedge CLK) begin
    tickDiv   = (tickDiv + 1) % 4;
    BAUD_TICK = (tickDiv == 0);
  end

  // Line state just after each baud tick: {TXD, TxRDY, TxEMT}.
  logic [2:0] txLog[$];
  bit         logEn = 1'b0;
  always @(posedge CLK) begin
    #1;
    if (logEn && BAUD_TICK) txLog.push_back({TXD, TxRDY, TxEMT});
  end

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [4:0]  mr;
    logic [7:0]  data;
    int          nBits;
    logic [15:0] frame;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  function automatic logic [2:0] logAt(input int i);
    if (i >= 0 && i < txLog.size()) return txLog[i];
    return 3'bxxx;
  endfunction

  function automatic int countTxd(input int first, input int last, input logic val);
    int n;
    logic [2:0] e;
    n = 0;
    for (int i = first; i <= last; i++) begin
      e = logAt(i);
      if (e[2] === val) n++;
    end
    return n;
  endfunction

  task automatic checkBits(input string nm, input int base, input logic [15:0] bits, input int n);
    logic [15:0] b;
    b = bits;
    for (int k = 0; k < n; k++)
      checkOutput($sformatf("%s bit%0d samples", nm, k),
                  16'(countTxd(base + 16*k, base + 16*k + 15, b[k])), 16'd16);
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [7:0] d);
    @(negedge CLK);
    bus.CS = 1'b1; bus.R_W = 1'b0; {bus.A1, bus.A0} = a; bus.DATA = d;
    @(negedge CLK);
    bus.CS = 1'b0;
  endtask

  task automatic busRead(input logic [1:0] a, output logic [7:0] d);
    @(negedge CLK);
    bus.CS = 1'b1; bus.R_W = 1'b1; {bus.A1, bus.A0} = a;
    #2 d = bus.DATA_OUT;
    @(negedge CLK);
    bus.CS = 1'b0; bus.R_W = 1'b0;
  endtask

  task automatic waitLog(input int n, input string nm);
    int budget;
    budget = 0;
    while (txLog.size() < n && budget < n * 6 + 100) begin
      @(negedge CLK);
      budget++;
    end
    checkOutput({nm, " tick log filled"}, 16'(txLog.size() >= n), 16'd1);
  endtask

  task automatic waitReady(input string nm);
    int budget;
    budget = 0;
    while (TxRDY !== 1'b1 && budget < 200) begin
      @(negedge CLK);
      budget++;
    end
    checkOutput({nm, " TxRDY after load"}, 16'(TxRDY), 16'd1);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [7:0] rd;
    logic [2:0] e;
    int         last;
    string      nm;
    nm = $sformatf("vec%0d", idx);
    busWrite(2'b00, {3'b000, v.mr});
    busRead(2'b00, rd);
    checkOutput({nm, " mode readback"}, 16'(rd), 16'({3'b000, v.mr}));
    txLog.delete();
    busWrite(2'b11, v.data);
    logEn = 1'b1;
    checkOutput({nm, " TxRDY after write"}, 16'(TxRDY), 16'd0);
    checkOutput({nm, " TxEMT after write"}, 16'(TxEMT), 16'd0);
    last = v.nBits * 16;
    waitLog(last + 1, nm);
    logEn = 1'b0;
    e = logAt(0);
    checkOutput({nm, " TXD after first tick"}, 16'(e[2]), 16'd0);
    checkOutput({nm, " TxRDY after load"}, 16'(e[1]), 16'd1);
    checkBits(nm, 0, v.frame, v.nBits);
    e = logAt(last - 1);
    checkOutput({nm, " TxEMT before last stop tick"}, 16'(e[0]), 16'd0);
    e = logAt(last);
    checkOutput({nm, " TxEMT after last stop tick"}, 16'(e[0]), 16'd1);
  endtask

  initial begin
    logic [7:0] rd;
    logic [2:0] e;

    // Frame bits LSB first: start, data, optional parity, stop(s).
    vecs[0] = '{5'b00011, 8'h55, 10, 16'h02AA};
    vecs[1] = '{5'b01110, 8'hC3, 10, 16'h0286};
    vecs[2] = '{5'b00000, 8'hF6,  7, 16'h006C};
    vecs[3] = '{5'b10100, 8'h0B,  9, 16'h01D6};
    vecs[4] = '{5'b00111, 8'h80, 11, 16'h0700};

    _RESET = 1'b0;
    bus.CS = 1'b0; bus.R_W = 1'b0; bus.A1 = 1'b0; bus.A0 = 1'b0; bus.DATA = 8'h00;
    repeat (3) @(negedge CLK);
    checkOutput("reset TXD", 16'(TXD), 16'd1);
    checkOutput("reset TxRDY", 16'(TxRDY), 16'd0);
    checkOutput("reset TxEMT", 16'(TxEMT), 16'd0);
    checkOutput("reset DATA_OUT idle", 16'(bus.DATA_OUT), 16'h00);
    _RESET = 1'b1;

    busRead(2'b10, rd);
    checkOutput("reset status read", 16'(rd), 16'h00);
    busRead(2'b00, rd);
    checkOutput("reset mode read", 16'(rd), 16'h03);

    busWrite(2'b10, 8'h01);
    checkOutput("enable TxRDY", 16'(TxRDY), 16'd1);
    checkOutput("enable TxEMT", 16'(TxEMT), 16'd1);
    busRead(2'b10, rd);
    checkOutput("enabled status read", 16'(rd), 16'h0C);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

    // Second character queued while the first is on the line.
    busWrite(2'b00, 8'h03);
    txLog.delete();
    busWrite(2'b11, 8'hA1);
    logEn = 1'b1;
    waitReady("b2b");
    busWrite(2'b11, 8'h3C);
    waitLog(321, "b2b");
    logEn = 1'b0;
    checkBits("b2b first", 0, 16'h0342, 10);
    e = logAt(160);
    checkOutput("b2b second start without gap", 16'(e[2]), 16'd0);
    checkBits("b2b second", 160, 16'h0278, 10);
    e = logAt(319);
    checkOutput("b2b TxEMT before end", 16'(e[0]), 16'd0);
    e = logAt(320);
    checkOutput("b2b TxEMT after end", 16'(e[0]), 16'd1);

    // Disable mid-frame with an overwritten THR, ignored write, then re-enable.
    busWrite(2'b11, 8'h11);
    waitReady("disable");
    busWrite(2'b11, 8'h5A);
    busWrite(2'b11, 8'h0F);
    busWrite(2'b10, 8'h02);
    checkOutput("disable TxRDY", 16'(TxRDY), 16'd0);
    checkOutput("disable TxEMT", 16'(TxEMT), 16'd0);
    busWrite(2'b11, 8'hFF);
    txLog.delete();
    logEn = 1'b1;
    waitLog(200, "disabled");
    logEn = 1'b0;
    checkOutput("disabled line stays high", 16'(countTxd(170, 199, 1'b0)), 16'd0);
    checkOutput("disabled TxRDY held", 16'(TxRDY), 16'd0);
    busRead(2'b10, rd);
    checkOutput("disabled status read", 16'(rd), 16'h00);
    txLog.delete();
    busWrite(2'b10, 8'h01);
    logEn = 1'b1;
    checkOutput("reenable TxRDY with THR full", 16'(TxRDY), 16'd0);
    waitLog(161, "reenable");
    logEn = 1'b0;
    checkBits("requeued", 0, 16'h021E, 10);
    e = logAt(160);
    checkOutput("requeued TxEMT after end", 16'(e[0]), 16'd1);

    // Reset-transmitter command mid-frame with a character waiting in THR.
    txLog.delete();
    busWrite(2'b11, 8'h00);
    logEn = 1'b1;
    waitLog(20, "txreset");
    logEn = 1'b0;
    e = logAt(19);
    checkOutput("txreset line low mid-frame", 16'(e[2]), 16'd0);
    busWrite(2'b11, 8'h77);
    busWrite(2'b10, 8'h04);
    checkOutput("txreset TXD", 16'(TXD), 16'd1);
    checkOutput("txreset TxRDY", 16'(TxRDY), 16'd0);
    checkOutput("txreset TxEMT", 16'(TxEMT), 16'd0);
    busWrite(2'b10, 8'h01);
    checkOutput("txreset reenable TxRDY", 16'(TxRDY), 16'd1);
    checkOutput("txreset THR emptied TxEMT", 16'(TxEMT), 16'd1);

    // Break commands issued while a frame is in flight.
    txLog.delete();
    busWrite(2'b11, 8'hF0);
    logEn = 1'b1;
    waitReady("break");
    busWrite(2'b10, 8'h09);
    waitLog(200, "break");
    logEn = 1'b0;
    checkBits("break host frame", 0, 16'h03E0, 10);
`ifdef MC68681_TX_BREAK_EN
    checkOutput("break line held low", 16'(countTxd(160, 199, 1'b0)), 16'd40);
    e = logAt(199);
    checkOutput("break TxEMT", 16'(e[0]), 16'd0);
    txLog.delete();
    busWrite(2'b10, 8'h10);
    logEn = 1'b1;
    waitLog(17, "break end");
    logEn = 1'b0;
    checkOutput("break end mark high", 16'(countTxd(0, 15, 1'b1)), 16'd16);
    e = logAt(14);
    checkOutput("break end TxEMT during mark", 16'(e[0]), 16'd0);
    e = logAt(15);
    checkOutput("break end TxEMT after mark", 16'(e[0]), 16'd1);
`else
    checkOutput("no break line idle", 16'(countTxd(160, 199, 1'b1)), 16'd40);
    e = logAt(199);
    checkOutput("no break TxEMT", 16'(e[0]), 16'd1);
    busWrite(2'b10, 8'h10);
    checkOutput("no break stop TXD", 16'(TXD), 16'd1);
    checkOutput("no break stop TxEMT", 16'(TxEMT), 16'd1);
`endif

    // Asynchronous reset in the middle of a start bit.
    busWrite(2'b11, 8'h00);
    waitReady("async");
    @(negedge CLK);
    checkOutput("async pre-reset TXD", 16'(TXD), 16'd0);
    #2 _RESET = 1'b0;
    #1;
    checkOutput("async reset TXD", 16'(TXD), 16'd1);
    checkOutput("async reset TxRDY", 16'(TxRDY), 16'd0);
    @(negedge CLK);
    _RESET = 1'b1;
    busRead(2'b00, rd);
    checkOutput("async reset mode read", 16'(rd), 16'h03);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mc68681_tx_channel.md
# mc68681_tx_channel

Transmit half of one MC68681 DUART channel: accepts characters written by the host into a transmit holding register (THR), serialises them onto TXD as asynchronous start/data/parity/stop frames paced by a 16x baud tick, and reports TxRDY/TxEMT status. TxRDY feeds the interrupt status/mask logic alongside the receiver's FFULL. Register decode for this channel's mode, command, status and THR is done inside the block from CS/A1/A0/R_W.

## Interface
- No parameters.
- CLK  in  1  system clock; all state on rising edge.
- _RESET  in  1  asynchronous, active-low reset.
- CS  in  1  channel-select from host bus decode.
- R_W  in  1  1 = read, 0 = write.
- A1, A0  in  1 each  register select: 00 mode (R/W), 10 status (R) / command (W), 11 THR (W).
- DATA  in  8  host write data.
- DATA_OUT  out  8  host read data; 0 when not reading.
- BAUD_TICK  in  1  one-CLK pulse at 16x bit rate.
- TXD  out  1  serial output, idle high.
- TxRDY  out  1  THR empty and transmitter enabled.
- TxEMT  out  1  THR empty, shifter idle, transmitter enabled.

## Operation
- Bus access acts once per CS assertion: write/read effects on the first CLK with CS=1 after a CLK with CS=0; held CS does not repeat.
- Mode register MR[4:0]: [1:0] char length = 5+n bits; [2] parity enable; [3] 1 = odd, 0 = even parity; [4] 1 = two stop bits. Reset value 5'b00011 (8N1). Read returns {3'b0, MR}.
- Command write: bit0 enable TX, bit1 disable TX (both set -> disable), bit2 reset transmitter (dominates all: FSM to IDLE, TXD=1, THR emptied, disabled, break cleared).
- Status read: {4'b0, TxEMT, TxRDY, 2'b0}. DATA_OUT combinational: MR or status when CS & R_W and matching address, else 8'h00.
- THR write: ignored when disabled; when THR full, overwrites (previous char lost); sets THR full.
- Disable: character in shifter completes; THR content kept but not loaded until re-enabled.
- FSM: IDLE -> START -> DATA -> (PARITY if MR[2]) -> STOP -> IDLE or START.
  - IDLE: TXD=1; on BAUD_TICK with THR full and enabled, copy THR to shifter, clear THR full, go START.
  - START: TXD=0 for 16 ticks. DATA: LSB first, char-length bits, 16 ticks each; bits above char length never sent.
  - PARITY: XOR of sent data bits, inverted if odd. STOP: TXD=1 for 16 or 32 ticks.
  - End of STOP: if THR full and enabled, load and go START directly (back-to-back, no idle gap); else IDLE.
- MR change mid-frame: takes effect at next load; shifter latches char length/parity/stop config at load.

## Timing
- Reset values: TXD=1, TxRDY=0, TxEMT=0, DATA_OUT=0, MR=5'b00011, disabled, THR empty, FSM IDLE.
- TxRDY falls the CLK after accepted THR write; rises the CLK after THR->shifter transfer.
- TxEMT falls the CLK after accepted THR write; rises the CLK after final stop-bit tick with THR empty.
- First TXD low: CLK after first BAUD_TICK following THR write while enabled and IDLE.
- Enable/disable update TxRDY/TxEMT the CLK after the command write.
- Simultaneous THR write and shifter load in same CLK: load takes old THR value, new write leaves THR full.
- _RESET asserted mid-frame: TXD returns high immediately (asynchronous).

## Configuration
- MC68681_TX_BREAK_EN defined: command bit3 = start break, bit4 = stop break. Start break: after current frame completes, TXD held low, THR not loaded, TxEMT=0. Stop break: TXD high for 16 ticks, then normal operation resumes. Reset-transmitter clears break.
- Not defined: bits 3/4 ignored; no break logic synthesised.

## Test plan
- Reset then status read (A=10) -> DATA_OUT=8'h00, TXD=1; mode read -> 8'h03.
- Enable, write 8'h55 at 8N1 -> TXD: 0, 1,0,1,0,1,0,1,0, 1, each exactly 16 ticks; TxRDY back to 1 one CLK after load; TxEMT=1 after stop.
- MR=5'b01110 (7 bits, odd parity, 1 stop), write 8'hC3 -> 7 data bits 1,1,0,0,0,0,1; parity bit 0; bit7 not sent.
- Write 8'hA1 then 8'h3C while first in flight -> second START immediately follows first STOP, no idle tick.
- Disable mid-frame with THR full -> current frame finishes, TXD stays 1, TxRDY=0; re-enable -> queued char transmits.
- With MC68681_TX_BREAK_EN: start break during frame -> TXD low after stop bit until stop break, then 16 ticks high; without macro, same writes have no effect.
